alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Issue-side controller for the 32-bit combinational ALU; sits between decode/register-read and writeback in the multi-cycle datapath variant.
- Accepts decoded RV32I ALU/branch requests over a valid/ready handshake, drives the ALU operand/select inputs, and holds them stable for a programmable number of cycles.
- Captures result and flags, then returns a registered response (write data, branch decision, error) over a second valid/ready handshake.

Parameters:
- EXEC_CYCLES, 1: cycles the ALU inputs are held before capture. Legal range 1..15.
- CNT_W, 4: width of the exec counter. Must satisfy 2^CNT_W > EXEC_CYCLES.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_opcode  in  7  instr[6:0]
- req_funct3  in  3  instr[14:12]
- req_funct7  in  7  instr[31:25]
- req_rs1  in  32  rs1 value
- req_rs2  in  32  rs2 value
- req_imm  in  32  sign-extended I-immediate
- req_rd  in  5  destination register
- alu_a  out  32  to ALU A_in
- alu_b  out  32  to ALU B_in
- alu_sel  out  4  to ALU ALU_Sel
- alu_out  in  32  from ALU_Out
- alu_zero  in  1  from Zero
- alu_ovf  in  1  from Overflow
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_rd  out  5  latched rd
- rsp_data  out  32  captured ALU result; 0 for branch or illegal
- rsp_we  out  1  1 only for legal ALU op with rd != 0
- rsp_taken  out  1  branch decision; 0 for non-branch
- rsp_err  out  1  illegal op (plus overflow trap, see option)

Behaviour:
- Reset (async, any state): state=IDLE, counter=0. All rsp_* = 0. alu_a = alu_b = 0, alu_sel = 4'b0000. req_ready = 1 after reset release.
- Decode, latched at accept:
  - R-type opcode 0110011, funct7=0000000: f3 000 ADD sel 0010; 111 AND 0000; 110 OR 0001; 010 SLT 0111.
  - R-type opcode 0110011, funct7=0100000 with f3=000: SUB sel 0110.
  - I-type opcode 0010011: f3 000 ADDI 0010; 111 ANDI 0000; 110 ORI 0001; 010 SLTI 0111. B operand = imm; funct7 ignored.
  - Branch opcode 1100011 (rs1, rs2):
    - BEQ (f3 000): sel 1111, taken = alu_out[0].
    - BNE (f3 001): sel 0110, taken = ~alu_zero.
    - BLT (f3 100): sel 0111, taken = alu_out[0].
    - BGE (f3 101): sel 0111, taken = ~alu_out[0].
  - All other encodings are illegal.
- FSM:
  - IDLE: req_ready=1. On req_valid, latch the request. Legal -> EXEC with counter=EXEC_CYCLES-1. Illegal -> RESP with err=1, data=0, we=0, taken=0, and alu_* left unchanged.
  - EXEC: req_ready=0. alu_a/alu_b/alu_sel driven from latched registers, stable for the whole state. Counter decrements each cycle. At the edge where counter==0, capture data/taken/flags and go to RESP.
  - RESP: rsp_valid=1, all rsp_* stable. On rsp_ready go to IDLE and clear rsp_valid. alu_* keep last values.
- Latency with EXEC_CYCLES=1: request accepted at edge N, rsp_valid high after edge N+1. Illegal op: rsp_valid high after edge N.
- No new request is accepted until the response handshake completes (single outstanding op). req_ready=0 in EXEC and RESP.
- rsp_ready high while rsp_valid=0 has no effect. rsp_ready asserted in the same cycle rsp_valid rises completes the handshake on that edge.
- Reset asserted mid-EXEC or mid-RESP aborts the op and drops the response; no partial output is produced.

Optional Feature:
- Macro ALU_OVF_TRAP_EN.
- Defined: for ADD, SUB, ADDI, alu_ovf sampled at capture sets rsp_err=1 and forces rsp_we=0. rsp_data still carries the wrapped result.
- Undefined: alu_ovf is ignored and rsp_err flags illegal ops only.

Test Plan:
- ADD rs1=5, rs2=7, rd=3, rsp_ready=1 -> alu_sel=0010 in EXEC; rsp_valid 2 cycles after accept; data=12, we=1, rd=3, err=0.
- SUB rs1=0x80000000, rs2=1 -> data=0x7FFFFFFF. With ALU_OVF_TRAP_EN: err=1, we=0. Without it: err=0, we=1.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1, we=0, data=0. Same operands with BGE -> taken=0.
- SLL (opcode 0110011, f3=001) -> rsp_valid 1 cycle after accept; err=1, we=0; alu_sel unchanged.
- EXEC_CYCLES=3, ORI rs1=0xF0, imm=0x0F, rsp_ready held low 4 cycles -> alu_* stable 3 cycles; req_ready=0 throughout; data=0xFF held until rsp_ready.
- rst_n pulsed low during EXEC of ADD -> rsp_valid never rises; state IDLE, req_ready=1; next ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer
// ----------------------------------------------------------------------------
// Issue-side controller for the 32-bit combinational ALU in the multi-cycle
// datapath. Accepts one decoded RV32I ALU/branch request at a time, drives
// the ALU operand/select inputs from registers for EXEC_CYCLES cycles, then
// captures the result and presents a registered response until consumed.
//
// Parameters:
//   EXEC_CYCLES  cycles the ALU inputs are held before capture (1..15)
//   CNT_W        exec counter width, 2**CNT_W > EXEC_CYCLES
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake
//   req_opcode/funct3/funct7   instruction fields used for decode
//   req_rs1/rs2/imm/rd         operands, I-immediate, destination register
//   alu_a/alu_b/alu_sel        registered drive to the external ALU
//   alu_out/alu_zero/alu_ovf   result and flags from the external ALU
//   rsp_valid / rsp_ready      response handshake
//   rsp_rd/data/we/taken/err   registered response fields
//
// Optional build macro:
//   ALU_OVF_TRAP_EN  when defined, signed overflow on ADD/SUB/ADDI raises
//                    rsp_err and suppresses rsp_we (data keeps wrapped value).
// ============================================================================
module alu_op_sequencer #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_opcode,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_imm,
    input  logic [4:0]  req_rd,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic        rsp_we,
    output logic        rsp_taken,
    output logic        rsp_err
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_EQ  = 4'b1111;

    // Branch condition kinds, latched at accept and resolved at capture.
    localparam logic [1:0] BR_EQ = 2'd0;
    localparam logic [1:0] BR_NE = 2'd1;
    localparam logic [1:0] BR_LT = 2'd2;
    localparam logic [1:0] BR_GE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      alu_a_reg, alu_b_reg;
    logic [3:0]       alu_sel_reg;
    logic             is_branch_reg;
    logic [1:0]       br_kind_reg;
    logic             ovf_chk_reg;
    logic [4:0]       rsp_rd_reg;
    logic [31:0]      rsp_data_reg;
    logic             rsp_we_reg, rsp_taken_reg, rsp_err_reg;

    // ------------------------------------------------------------------
    // Request decode (combinational, consumed only on the accept edge)
    // ------------------------------------------------------------------
    logic       dec_legal;
    logic [3:0] dec_sel;
    logic       dec_use_imm;
    logic       dec_branch;
    logic [1:0] dec_br_kind;
    logic       dec_ovf_chk;

    always_comb begin
        dec_legal   = 1'b0;
        dec_sel     = SEL_AND;
        dec_use_imm = 1'b0;
        dec_branch  = 1'b0;
        dec_br_kind = BR_EQ;
        dec_ovf_chk = 1'b0;
        case (req_opcode)
            OP_R: begin
                if (req_funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    case (req_funct3)
                        3'b000:  begin dec_sel = SEL_ADD; dec_ovf_chk = 1'b1; end
                        3'b111:  dec_sel = SEL_AND;
                        3'b110:  dec_sel = SEL_OR;
                        3'b010:  dec_sel = SEL_SLT;
                        default: dec_legal = 1'b0;
                    endcase
                end else if (req_funct7 == 7'b0100000 && req_funct3 == 3'b000) begin
                    dec_legal   = 1'b1;
                    dec_sel     = SEL_SUB;
                    dec_ovf_chk = 1'b1;
                end
            end
            OP_I: begin
                // funct7 bits are part of the immediate here and ignored.
                dec_legal   = 1'b1;
                dec_use_imm = 1'b1;
                case (req_funct3)
                    3'b000:  begin dec_sel = SEL_ADD; dec_ovf_chk = 1'b1; end
                    3'b111:  dec_sel = SEL_AND;
                    3'b110:  dec_sel = SEL_OR;
                    3'b010:  dec_sel = SEL_SLT;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_B: begin
                dec_legal  = 1'b1;
                dec_branch = 1'b1;
                case (req_funct3)
                    3'b000:  begin dec_sel = SEL_EQ;  dec_br_kind = BR_EQ; end
                    3'b001:  begin dec_sel = SEL_SUB; dec_br_kind = BR_NE; end
                    3'b100:  begin dec_sel = SEL_SLT; dec_br_kind = BR_LT; end
                    3'b101:  begin dec_sel = SEL_SLT; dec_br_kind = BR_GE; end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    logic accept, capture;
    assign accept  = (state_reg == IDLE) && req_valid;
    assign capture = (state_reg == EXEC) && (cnt_reg == '0);

    // Branch decision from the ALU result seen at the capture edge.
    logic taken_calc;
    always_comb begin
        taken_calc = 1'b0;
        case (br_kind_reg)
            BR_EQ:   taken_calc = alu_out[0];
            BR_NE:   taken_calc = ~alu_zero;
            BR_LT:   taken_calc = alu_out[0];
            BR_GE:   taken_calc = ~alu_out[0];
            default: taken_calc = 1'b0;
        endcase
    end

    logic ovf_trap;
`ifdef ALU_OVF_TRAP_EN
    assign ovf_trap = ovf_chk_reg & alu_ovf;
`else
    // Overflow is ignored in this build; tie off the flag paths.
    assign ovf_trap = 1'b0;
    logic unused_ovf;
    assign unused_ovf = &{1'b0, alu_ovf, ovf_chk_reg};
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = dec_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_reg)
            IDLE:    req_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_sel_reg   <= 4'b0000;
            is_branch_reg <= 1'b0;
            br_kind_reg   <= BR_EQ;
            ovf_chk_reg   <= 1'b0;
            rsp_rd_reg    <= '0;
            rsp_data_reg  <= '0;
            rsp_we_reg    <= 1'b0;
            rsp_taken_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                rsp_rd_reg <= req_rd;
                if (dec_legal) begin
                    alu_a_reg     <= req_rs1;
                    alu_b_reg     <= dec_use_imm ? req_imm : req_rs2;
                    alu_sel_reg   <= dec_sel;
                    is_branch_reg <= dec_branch;
                    br_kind_reg   <= dec_br_kind;
                    ovf_chk_reg   <= dec_ovf_chk;
                    cnt_reg       <= CNT_LOAD;
                end else begin
                    // Illegal op: respond immediately, ALU drive untouched.
                    rsp_data_reg  <= '0;
                    rsp_we_reg    <= 1'b0;
                    rsp_taken_reg <= 1'b0;
                    rsp_err_reg   <= 1'b1;
                end
            end else if (state_reg == EXEC) begin
                if (capture) begin
                    rsp_data_reg  <= is_branch_reg ? 32'd0 : alu_out;
                    rsp_taken_reg <= is_branch_reg & taken_calc;
                    rsp_we_reg    <= ~is_branch_reg & (rsp_rd_reg != 5'd0) & ~ovf_trap;
                    rsp_err_reg   <= ovf_trap;
                end else begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end
        end
    end

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_sel   = alu_sel_reg;
    assign rsp_rd    = rsp_rd_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_we    = rsp_we_reg;
    assign rsp_taken = rsp_taken_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
